iterative_shift_register: RTL and testbench

Parametrised multi-mode shift register that shifts a loaded operand one bit per clock, with the shift count and mode set per operation.
It is the successor to the fixed single-step arithmetic-right shift register. It adds logical and arithmetic shifts, rotates, serial-insert modes, variable shift count, and a start/busy/done handshake.
It sits in the datapath as a small-area alternative to a barrel shifter.

---
 rtl/iterative_shift_register.sv | 167 ++++++++++++++++
 tb/tb_iterative_shift_register.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/iterative_shift_register.sv
// iterative_shift_register
// Multi-mode shift register that applies one shift/rotate step per clock.
// An operation is loaded with start, runs for `amount` steps, then reports
// completion with a single-cycle done pulse. This is a small-area alternative
// to a full barrel shifter in the datapath.

module iterative_shift_register #(
  parameter int WIDTH = 128,
  parameter int AMT_W = 7
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [AMT_W-1:0] amount,
  input  logic [WIDTH-1:0] D,
  input  logic             serial_in,
  output logic [WIDTH-1:0] Q,
  output logic             busy,
  output logic             done,
  output logic             serial_out
);

  // Operation encodings, latched at accept time.
  typedef enum logic [2:0] {
    MODE_LSL = 3'd0,
    MODE_LSR = 3'd1,
    MODE_ASR = 3'd2,
    MODE_ROL = 3'd3,
    MODE_ROR = 3'd4,
    MODE_SRI = 3'd5,
    MODE_SLI = 3'd6,
    MODE_NOP = 3'd7
  } mode_e;

  // Control states: SHIFT runs the steps, DONE is the one-cycle completion slot.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam logic [AMT_W-1:0] CNT_ZERO = {AMT_W{1'b0}};
  localparam logic [AMT_W-1:0] CNT_ONE  = {{(AMT_W-1){1'b0}}, 1'b1};

  state_e           state_r;
  mode_e            mode_r;
  logic [AMT_W-1:0] cnt_r;
  logic [WIDTH-1:0] q_r;
  logic             busy_r;
  logic             done_r;
  logic             so_r;

  logic [WIDTH-1:0] step_q_s;
  logic             step_so_s;
  logic             accept_s;
  logic             amount_zero_s;

  // One step of the selected operation. Returns {new serial_out, new Q}.
  // Right-moving modes emit the old LSB, left-moving modes the old MSB;
  // NOP leaves both Q and serial_out untouched.
  function automatic logic [WIDTH:0] step_fn(
    input logic [WIDTH-1:0] q,
    input mode_e            m,
    input logic             sin,
    input logic             so
  );
    logic [WIDTH:0] r;
    case (m)
      MODE_LSL: r = {q[WIDTH-1], q[WIDTH-2:0], 1'b0};
      MODE_LSR: r = {q[0], 1'b0, q[WIDTH-1:1]};
      MODE_ASR: r = {q[0], q[WIDTH-1], q[WIDTH-1:1]};
      MODE_ROL: r = {q[WIDTH-1], q[WIDTH-2:0], q[WIDTH-1]};
      MODE_ROR: r = {q[0], q[0], q[WIDTH-1:1]};
      MODE_SRI: r = {q[0], sin, q[WIDTH-1:1]};
      MODE_SLI: r = {q[WIDTH-1], q[WIDTH-2:0], sin};
      MODE_NOP: r = {so, q};
      default:  r = {so, q};
    endcase
    return r;
  endfunction

  // Next-step datapath value, computed from the current register contents.
  always_comb begin
    step_q_s  = q_r;
    step_so_s = so_r;
    {step_so_s, step_q_s} = step_fn(q_r, mode_r, serial_in, so_r);
  end

  // Accept qualifier: a new operation may load from IDLE or from the DONE slot.
  always_comb begin
    accept_s      = 1'b0;
    amount_zero_s = (amount == CNT_ZERO);
    if (start && ((state_r == ST_IDLE) || (state_r == ST_DONE))) begin
      accept_s = 1'b1;
    end else begin
      accept_s = 1'b0;
    end
  end

  // Control FSM and datapath registers; busy/done/serial_out are registered.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= ST_IDLE;
      mode_r  <= MODE_LSL;
      cnt_r   <= CNT_ZERO;
      q_r     <= {WIDTH{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      so_r    <= 1'b0;
    end else if (accept_s) begin
      // Load a new operation; a zero count completes in the very next cycle.
      q_r    <= D;
      mode_r <= mode_e'(mode);
      cnt_r  <= amount;
      so_r   <= 1'b0;
      if (amount_zero_s) begin
        state_r <= ST_DONE;
        busy_r  <= 1'b0;
        done_r  <= 1'b1;
      end else begin
        state_r <= ST_SHIFT;
        busy_r  <= 1'b1;
        done_r  <= 1'b0;
      end
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
        ST_SHIFT: begin
          q_r   <= step_q_s;
          so_r  <= step_so_s;
          cnt_r <= cnt_r - CNT_ONE;
          // cnt_r never reaches zero here: the final step hands over to DONE.
          if (cnt_r == CNT_ONE) begin
            state_r <= ST_DONE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end else begin
            state_r <= ST_SHIFT;
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign Q          = q_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign serial_out = so_r;

endmodule

// File: tb/tb_iterative_shift_register.sv
// Directed bench for iterative_shift_register: an 8-bit instance driven from a
// vector table plus hand-written sequences, and a 128-bit instance for the
// full-width corner cases.

module tb_iterative_shift_register;

  logic clock = 1'b0;
  logic reset = 1'b1;

  always #5 clock = ~clock;

  // 8-bit instance
  logic         start8 = 1'b0;
  logic [2:0]   mode8 = 3'd0;
  logic [2:0]   amount8 = 3'd0;
  logic [7:0]   d8 = 8'h00;
  logic         sin8 = 1'b0;
  logic [7:0]   q8;
  logic         busy8, done8, so8;

  // 128-bit instance
  logic         start128 = 1'b0;
  logic [2:0]   mode128 = 3'd0;
  logic [6:0]   amount128 = 7'd0;
  logic [127:0] d128 = 128'd0;
  logic         sin128 = 1'b0;
  logic [127:0] q128;
  logic         busy128, done128, so128;

  iterative_shift_register #(.WIDTH(8), .AMT_W(3)) dut8 (
    .clock(clock), .reset(reset), .start(start8), .mode(mode8),
    .amount(amount8), .D(d8), .serial_in(sin8), .Q(q8),
    .busy(busy8), .done(done8), .serial_out(so8)
  );

  iterative_shift_register #(.WIDTH(128), .AMT_W(7)) dut128 (
    .clock(clock), .reset(reset), .start(start128), .mode(mode128),
    .amount(amount128), .D(d128), .serial_in(sin128), .Q(q128),
    .busy(busy128), .done(done128), .serial_out(so128)
  );

  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    logic [2:0] mode;
    logic [2:0] amount;
    logic [7:0] d;
    logic       sin;
    logic [7:0] exp_q;
    logic       exp_so;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Start an 8-bit operation (accept edge included).
  task automatic start_op8(input logic [2:0] m, input logic [2:0] a, input logic [7:0] d);
    start8 = 1'b1; mode8 = m; amount8 = a; d8 = d;
    tick();
    start8 = 1'b0; mode8 = 3'd7; amount8 = 3'd0; d8 = 8'hEE;
  endtask

  // Wait for done on the 8-bit instance; returns number of edges waited.
  task automatic wait_done8(output int n);
    n = 0;
    while (!done8 && n < 300) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int n;

    //            mode   amt   D      sin   Q      so
    vecs[0]  = '{3'd2, 3'd3, 8'hB4, 1'b0, 8'hF6, 1'b1}; // ASR
    vecs[1]  = '{3'd0, 3'd1, 8'h81, 1'b0, 8'h02, 1'b1}; // LSL
    vecs[2]  = '{3'd4, 3'd4, 8'h81, 1'b0, 8'h18, 1'b0}; // ROR
    vecs[3]  = '{3'd1, 3'd2, 8'h81, 1'b1, 8'h20, 1'b0}; // LSR (serial_in ignored)
    vecs[4]  = '{3'd3, 3'd3, 8'h81, 1'b0, 8'h0C, 1'b0}; // ROL
    vecs[5]  = '{3'd6, 3'd3, 8'h00, 1'b1, 8'h07, 1'b0}; // SLI
    vecs[6]  = '{3'd7, 3'd4, 8'hA5, 1'b1, 8'hA5, 1'b0}; // NOP
    vecs[7]  = '{3'd2, 3'd7, 8'h7F, 1'b0, 8'h00, 1'b1}; // ASR positive, max count
    vecs[8]  = '{3'd0, 3'd0, 8'h5A, 1'b0, 8'h5A, 1'b0}; // amount 0
    vecs[9]  = '{3'd5, 3'd7, 8'h00, 1'b1, 8'hFE, 1'b0}; // SRI
    vecs[10] = '{3'd1, 3'd7, 8'h80, 1'b0, 8'h01, 1'b0}; // LSR max count

    // Reset state
    tick(); tick();
    reset = 1'b0;
    check("rst_q", q8, 8'h00);
    check("rst_busy", busy8, 1'b0);
    check("rst_done", done8, 1'b0);
    check("rst_so", so8, 1'b0);
    check("rst_q128", q128, 128'd0);

    // Table-driven operations
    for (int i = 0; i < 11; i++) begin
      sin8 = vecs[i].sin;
      start_op8(vecs[i].mode, vecs[i].amount, vecs[i].d);
      check($sformatf("v%0d_busy0", i), busy8, (vecs[i].amount != 3'd0));
      wait_done8(n);
      check($sformatf("v%0d_lat", i), n, vecs[i].amount);
      check($sformatf("v%0d_q", i), q8, vecs[i].exp_q);
      check($sformatf("v%0d_so", i), so8, vecs[i].exp_so);
      check($sformatf("v%0d_busy_done", i), busy8, 1'b0);
      tick();
      check($sformatf("v%0d_done_pulse", i), done8, 1'b0);
      check($sformatf("v%0d_q_hold", i), q8, vecs[i].exp_q);
    end

    // Reset in the middle of an ASR: D=83 -> C1 -> E0 after 2 shifts
    sin8 = 1'b0;
    start_op8(3'd2, 3'd5, 8'h83);
    tick(); tick();
    check("mid_q", q8, 8'hE0);
    check("mid_so", so8, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mrst_q", q8, 8'h00);
    check("mrst_busy", busy8, 1'b0);
    check("mrst_done", done8, 1'b0);
    check("mrst_so", so8, 1'b0);
    tick();
    check("mrst_idle_done", done8, 1'b0);
    start_op8(3'd0, 3'd1, 8'h81);
    wait_done8(n);
    check("post_rst_lat", n, 1);
    check("post_rst_q", q8, 8'h02);
    check("post_rst_so", so8, 1'b1);

    // SRI with per-step serial_in 1,0,1, then amount=0 start in the DONE cycle
    start_op8(3'd5, 3'd3, 8'h00);
    sin8 = 1'b1; tick();
    sin8 = 1'b0; tick();
    sin8 = 1'b1; tick();
    check("sri_done", done8, 1'b1);
    check("sri_q", q8, 8'hA0);
    start8 = 1'b1; mode8 = 3'd0; amount8 = 3'd0; d8 = 8'h3C;
    tick();
    start8 = 1'b0;
    check("b2b_done", done8, 1'b1);
    check("b2b_busy", busy8, 1'b0);
    check("b2b_q", q8, 8'h3C);
    check("b2b_so", so8, 1'b0);
    tick();
    check("b2b_done_end", done8, 1'b0);
    check("b2b_q_hold", q8, 8'h3C);

    // 128-bit ASR of the sign bit over 127 steps
    start128 = 1'b1; mode128 = 3'd2; amount128 = 7'd127;
    d128 = 128'h8000_0000_0000_0000_0000_0000_0000_0000;
    tick();
    start128 = 1'b0; d128 = 128'd0;
    n = 0;
    while (!done128 && n < 300) begin tick(); n++; end
    check("w128_asr_lat", n, 127);
    check("w128_asr_q", q128, {128{1'b1}});
    check("w128_asr_so", so128, 1'b0);
    tick();

    // 128-bit legacy single-step ASR
    start128 = 1'b1; mode128 = 3'd2; amount128 = 7'd1;
    d128 = 128'h8000_0000_0000_0000_0000_0000_0000_0001;
    tick();
    start128 = 1'b0;
    tick();
    check("w128_leg_done", done128, 1'b1);
    check("w128_leg_q", q128, 128'hC000_0000_0000_0000_0000_0000_0000_0000);
    check("w128_leg_so", so128, 1'b1);
    tick();

    // 128-bit LSL with a start pulse while busy that must be ignored
    start128 = 1'b1; mode128 = 3'd0; amount128 = 7'd4; d128 = 128'd1;
    tick();
    start128 = 1'b0;
    tick();
    start128 = 1'b1; mode128 = 3'd4; amount128 = 7'd1; d128 = {128{1'b1}};
    tick();
    start128 = 1'b0;
    check("w128_busy_mid", busy128, 1'b1);
    n = 2;
    while (!done128 && n < 300) begin tick(); n++; end
    check("w128_ign_lat", n, 4);
    check("w128_ign_q", q128, 128'h10);
    check("w128_ign_so", so128, 1'b0);
    tick();
    check("w128_ign_idle", done128, 1'b0);
    check("w128_ign_hold", q128, 128'h10);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
